// File: rtl/univ_bin_counter.sv
// univ_bin_counter
// N-bit universal binary counter. It supports synchronous clear,
// parallel load, and up/down counting with a count enable. It also
// provides max/min terminal-count flags.
// q comes straight from the state register. The flags are decodes of q
// alone, so they are valid in the same cycle that q changes.

module univ_bin_counter #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         syn_clr,
    input  logic         load,
    input  logic         en,
    input  logic         up,
    input  logic [N-1:0] d,
    output logic         max,
    output logic         min,
    output logic [N-1:0] q
);

    logic [N-1:0] q_reg;
    logic [N-1:0] q_next;

    // Next-state selection: clear > load > count up/down > hold.
    always_comb begin
        // NOTE: default first so every path assigns q_next; no latch is inferred.
        q_next = q_reg;
        if (syn_clr) begin
            q_next = '0;
        end else if (load) begin
            q_next = d;
        end else if (en) begin
            // N-bit add/subtract; the carry/borrow is dropped, so wrap is silent.
            if (up) begin
                q_next = q_reg + 1'b1;
            end else begin
                q_next = q_reg - 1'b1;
            end
        end
    end

    // State register with asynchronous active-low reset to zero.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: non-blocking assignment for sequential state.
        if (!reset) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_next;
        end
    end

    // Terminal-count decodes of the current count only.
    assign max = &q_reg;
    assign min = ~|q_reg;
    assign q   = q_reg;

endmodule

// File: tb/tb_univ_bin_counter.sv
// tb_univ_bin_counter
// Directed test of univ_bin_counter with N = 8. Each step drives inputs
// and pushes the expected count onto a scoreboard queue. After the
// rising edge, the step pops that entry and compares q, max and min.

module tb_univ_bin_counter;

    localparam int N = 8;

    typedef struct {
        string        tag;
        logic [N-1:0] q;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         syn_clr;
    logic         load;
    logic         en;
    logic         up;
    logic [N-1:0] d;
    logic         max;
    logic         min;
    logic [N-1:0] q;

    exp_t         sb[$];
    logic [N-1:0] model_q;
    int           n_checks;
    int           n_passed;

    univ_bin_counter #(.N(N)) dut (
        .clk     (clk),
        .reset   (reset),
        .syn_clr (syn_clr),
        .load    (load),
        .en      (en),
        .up      (up),
        .d       (d),
        .max     (max),
        .min     (min),
        .q       (q)
    );

    // 10-unit clock; the first rising edge is at t = 5.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run always ends.
    initial begin
        #50000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "time limit reached");
    end

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_checks++;
        assert (obs === exp) n_passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Pop the oldest expectation and compare it against the current outputs.
    task automatic observe();
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 8'd1, 8'd0);
        end else begin
            e = sb.pop_front();
            check({e.tag, "_q"},   q,          e.q);
            check({e.tag, "_max"}, {7'd0, max}, {7'd0, (e.q == 8'hFF)});
            check({e.tag, "_min"}, {7'd0, min}, {7'd0, (e.q == 8'h00)});
        end
    endtask

    // Drive one set of controls. Predict the result with the priority
    // model, wait for the edge, then check.
    task automatic step(input string tag, input logic sc, input logic ld,
                        input logic e, input logic u, input logic [N-1:0] dv);
        exp_t x;
        syn_clr = sc;
        load    = ld;
        en      = e;
        up      = u;
        d       = dv;
        if (sc)       model_q = '0;
        else if (ld)  model_q = dv;
        else if (e)   model_q = u ? model_q + 8'd1 : model_q - 8'd1;
        x.tag = tag;
        x.q   = model_q;
        sb.push_back(x);
        @(posedge clk);
        #1;
        observe();
    endtask

    // Check an expectation right away, with no clock edge in between.
    task automatic expect_now(input string tag, input logic [N-1:0] ev);
        exp_t x;
        x.tag = tag;
        x.q   = ev;
        sb.push_back(x);
        observe();
    endtask

    initial begin
        n_checks = 0;
        n_passed = 0;
        model_q  = '0;

        // Reset is high at t = 0. The controls request load/count.
        reset = 1'b1; syn_clr = 1'b0; load = 1'b1; en = 1'b1; up = 1'b1; d = 8'hA5;
        #2 reset = 1'b0;
        #1 expect_now("async_reset", 8'd0);
        @(posedge clk);
        #1 expect_now("reset_held_edge", 8'd0);

        // Release reset with all controls at 0; q must stay at 0.
        #2 reset = 1'b1;
        step("release_idle0", 0, 0, 0, 0, 8'd0);
        step("release_idle1", 0, 0, 0, 0, 8'd0);

        // Clear beats load and count.
        step("clr_beats_load", 1, 1, 1, 1, 8'd1);
        step("load_one",       0, 1, 0, 0, 8'd1);

        // Up count 1 -> 4, then hold for two edges.
        step("up_2", 0, 0, 1, 1, 8'd0);
        step("up_3", 0, 0, 1, 1, 8'd0);
        step("up_4", 0, 0, 1, 1, 8'd0);
        step("hold_a", 0, 0, 0, 1, 8'd77);
        step("hold_b", 0, 0, 0, 0, 8'd77);
        check("literal_four", q, 8'd4);

        // Up wrap: 254 -> 255 -> 0.
        step("load_254", 0, 1, 1, 0, 8'd254);
        step("up_255",   0, 0, 1, 1, 8'd0);
        check("literal_max", {7'd0, max}, 8'd1);
        step("up_wrap",  0, 0, 1, 1, 8'd0);

        // Down wrap: 2 -> 1 -> 0 -> 255 -> 254.
        step("load_2",    0, 1, 0, 0, 8'd2);
        step("dn_1",      0, 0, 1, 0, 8'd0);
        step("dn_0",      0, 0, 1, 0, 8'd0);
        step("dn_wrap",   0, 0, 1, 0, 8'd0);
        step("dn_254",    0, 0, 1, 0, 8'd0);
        check("literal_254", q, 8'd254);

        // A clear during a down count still wins.
        step("clr_in_count", 1, 0, 1, 0, 8'd9);

        // Async reset mid-count at 37, then restart counting from 0.
        step("load_36", 0, 1, 0, 0, 8'd36);
        step("up_37",   0, 0, 1, 1, 8'd0);
        #2 reset = 1'b0;
        #1 model_q = '0;
        expect_now("mid_reset", 8'd0);
        #2 reset = 1'b1;
        step("restart_1", 0, 0, 1, 1, 8'd0);
        step("restart_2", 0, 0, 1, 1, 8'd0);
        step("restart_3", 0, 0, 1, 1, 8'd0);
        check("literal_three", q, 8'd3);

        check("sb_drained", 8'(sb.size()), 8'd0);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
